l2_req_arbiter: RTL and testbench
=================================

Name: l2_req_arbiter

Overview:
- Shares the single L2 SRAM request port between the host interface (HTIF) and core0.
- Registers one granted request in an output holding stage and arbitrates round-robin.
- Tracks outstanding loads per requester and routes L2 responses and nacks back by the tag's source bit.
- Sits between the core/HTIF request buses and the 256K L2 SRAM macro.

Parameters:
- ADDR_W, 26, L2 address width; the 14-bit HTIF address is zero-extended to it.
- DATA_W, 128, request/response data width.
- TAG_W, 4, requester tag width; the L2 tag is TAG_W+1 bits, MSB = source (1 = HTIF).
- MAX_OUT, 4, maximum outstanding loads per requester; 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- htif_req_val / htif_req_rdy  in / out  1 / 1  HTIF request handshake
- htif_req_rw  in  1  1 = store
- htif_req_addr  in  14  HTIF address
- htif_req_data  in  DATA_W  HTIF store data
- htif_req_tag  in  TAG_W  HTIF tag
- htif_resp_val / htif_resp_nack  out  1 / 1  HTIF response / nack strobes
- htif_resp_data  out  DATA_W  HTIF response data
- htif_resp_tag  out  TAG_W  HTIF response tag
- core_req_val / core_req_rdy / core_req_rw  in / out / in  1 / 1 / 1  core0 request handshake and direction
- core_req_addr  in  ADDR_W  core0 address
- core_req_data  in  DATA_W  core0 store data
- core_req_tag  in  TAG_W  core0 tag
- core_resp_val / core_resp_nack  out  1 / 1  core0 response / nack strobes
- core_resp_data  out  DATA_W  core0 response data
- core_resp_tag  out  TAG_W  core0 response tag
- mem_req_val / mem_req_rdy  out / in  1 / 1  L2 request handshake
- mem_req_rw  out  2  00 core load, 01 core store, 10 HTIF load, 11 HTIF store
- mem_req_addr  out  ADDR_W  L2 address
- mem_req_data  out  DATA_W  L2 store data
- mem_req_tag  out  TAG_W+1  L2 tag
- mem_resp_val / mem_resp_nack  in / in  1 / 1  L2 response / nack strobes
- mem_resp_data  in  DATA_W  L2 response data
- mem_resp_tag  in  TAG_W+1  L2 response tag

Behaviour:
- Single clock clk; reset is synchronous and active-high. Reset clears:
  - the holding stage (mem_req_val=0);
  - FSM to IDLE;
  - round-robin pointer to HTIF-first (prio=1);
  - both outstanding counters to 0;
  - all *_resp_val and *_resp_nack to 0.
- Reset mid-transaction drops the held request and the counters; later L2 responses are still routed by tag but do not decrement below 0.
- FSM, two states:
  - IDLE: holding stage empty.
  - HOLD: mem_req_val=1, fields stable until mem_req_rdy.
- Eligibility: a requester is eligible if req_val=1, and either it is a store or its outstanding count < MAX_OUT.
- IDLE:
  - rdy is asserted combinationally only to the winner among eligible requesters. With both eligible, the one selected by prio wins.
  - On the winner's val&rdy, capture rw/addr/data/tag into the holding stage, go to HOLD, and flip prio to the other requester.
  - Request-to-mem_req_val latency is 1 cycle.
- HOLD: both req_rdy=0. On mem_req_rdy, go to IDLE. No back-to-back grant; throughput is one request per 2 cycles.
- Encoding:
  - mem_req_rw = {src, rw}.
  - mem_req_tag = {src, tag}.
  - HTIF address is zero-extended to ADDR_W.
- Outstanding counter of a source:
  - +1 when a load leaves the holding stage (mem_req_val&mem_req_rdy);
  - -1 on mem_resp_val or mem_resp_nack for a load tag of that source;
  - same-cycle +1/-1 nets to no change;
  - saturates at 0 and MAX_OUT.
  - Stores are not counted, but a store nack is still forwarded.
- Response routing is registered, 1-cycle latency:
  - mem_resp_tag MSB selects the destination.
  - The destination's resp_val/resp_nack mirror the L2 strobes; data and tag[TAG_W-1:0] are passed through.
  - The other requester's strobes are 0.
- The two requesters have no response backpressure.

Optional Feature:
- Macro L2ARB_PERF_CNT_EN.
- Defined: adds output ports perf_htif_grants [31:0], perf_core_grants [31:0] and perf_stall_cycles [31:0].
  - Grant counters increment per accepted request.
  - Stall counter increments each cycle any req_val=1 but no grant occurs.
  - All counters wrap at 2^32 and are cleared by reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then core load addr=0x100, tag=3 with mem_req_rdy=1 -> next cycle mem_req_val=1, rw=00, tag=0x03, core_req_rdy low for that HOLD cycle.
- HTIF and core both requesting continuously, mem_req_rdy=1 -> grants alternate HTIF, core, HTIF, core, starting with HTIF after reset.
- HTIF store addr=0x3FFF -> mem_req_addr=0x0003FFF, rw=11, tag MSB=1; HTIF count stays 0.
- Issue 4 core loads with no responses (MAX_OUT=4) -> 5th core load held off (rdy=0) while an HTIF request is still granted. Return one response -> core granted next IDLE.
- mem_resp_nack with tag=0x12 -> one cycle later htif_resp_nack=1, htif_resp_tag=2, core strobes 0, HTIF count -1.
- Assert reset while in HOLD with mem_req_rdy=0 -> next cycle mem_req_val=0, counters 0, prio=HTIF.

Source files
------------

// File: rtl/l2_req_arbiter.sv
// Arbitrates the single L2 SRAM request port between HTIF and core0 through a one-entry
// holding stage, routing responses back by tag source bit. L2ARB_PERF_CNT_EN adds perf counters.
module l2_req_arbiter #(
  parameter int unsigned ADDR_W  = 26,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              htif_req_val,
  output logic              htif_req_rdy,
  input  logic              htif_req_rw,
  input  logic [13:0]       htif_req_addr,
  input  logic [DATA_W-1:0] htif_req_data,
  input  logic [TAG_W-1:0]  htif_req_tag,
  output logic              htif_resp_val,
  output logic              htif_resp_nack,
  output logic [DATA_W-1:0] htif_resp_data,
  output logic [TAG_W-1:0]  htif_resp_tag,
  input  logic              core_req_val,
  output logic              core_req_rdy,
  input  logic              core_req_rw,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [DATA_W-1:0] core_req_data,
  input  logic [TAG_W-1:0]  core_req_tag,
  output logic              core_resp_val,
  output logic              core_resp_nack,
  output logic [DATA_W-1:0] core_resp_data,
  output logic [TAG_W-1:0]  core_resp_tag,
  output logic              mem_req_val,
  input  logic              mem_req_rdy,
  output logic [1:0]        mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic [TAG_W:0]    mem_req_tag,
  input  logic              mem_resp_val,
  input  logic              mem_resp_nack,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic [TAG_W:0]    mem_resp_tag
`ifdef L2ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_htif_grants,
  output logic [31:0]       perf_core_grants,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int unsigned CntW  = 4;
  localparam int unsigned NTags = 1 << TAG_W;
  localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUT);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e               state_q, state_d;
  logic                 prio_q;
  logic [1:0]           rw_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    data_q;
  logic [TAG_W:0]       tag_q;
  logic [CntW-1:0]      cnt_htif_q, cnt_htif_d, cnt_core_q, cnt_core_d;
  logic [NTags-1:0]     pend_htif_q, pend_htif_d, pend_core_q, pend_core_d;
  logic                 resp_hv_q, resp_hn_q, resp_cv_q, resp_cn_q;
  logic [DATA_W-1:0]    resp_data_q;
  logic [TAG_W-1:0]     resp_tag_q;

  logic elig_htif, elig_core, pick_htif, pick_core, grant;
  logic load_out, inc_htif, inc_core, resp_any, dec_htif, dec_core;
  logic [TAG_W-1:0] resp_idx;

  assign elig_htif = htif_req_val & (htif_req_rw | (cnt_htif_q < MaxOut));
  assign elig_core = core_req_val & (core_req_rw | (cnt_core_q < MaxOut));
  assign pick_htif = elig_htif & (prio_q | ~elig_core);
  assign pick_core = elig_core & ~pick_htif;
  assign grant     = htif_req_rdy | core_req_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (pick_htif || pick_core) state_d = StHold;
      StHold: if (mem_req_rdy) state_d = StIdle;
    endcase
  end

  always_comb begin
    htif_req_rdy = 1'b0;
    core_req_rdy = 1'b0;
    mem_req_val  = 1'b0;
    unique case (state_q)
      StIdle: begin
        htif_req_rdy = pick_htif;
        core_req_rdy = pick_core;
      end
      StHold: mem_req_val = 1'b1;
    endcase
  end

  // Whoever wins hands priority to the other requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b1;
    end else if (grant) begin
      prio_q <= core_req_rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (htif_req_rdy) begin
      rw_q   <= {1'b1, htif_req_rw};
      addr_q <= ADDR_W'(htif_req_addr);
      data_q <= htif_req_data;
      tag_q  <= {1'b1, htif_req_tag};
    end else if (core_req_rdy) begin
      rw_q   <= {1'b0, core_req_rw};
      addr_q <= core_req_addr;
      data_q <= core_req_data;
      tag_q  <= {1'b0, core_req_tag};
    end
  end

  assign mem_req_rw   = rw_q;
  assign mem_req_addr = addr_q;
  assign mem_req_data = data_q;
  assign mem_req_tag  = tag_q;

  // Per-tag pending bits tell load responses apart from store responses.
  assign load_out = mem_req_val & mem_req_rdy & ~rw_q[0];
  assign inc_htif = load_out & rw_q[1];
  assign inc_core = load_out & ~rw_q[1];
  assign resp_any = mem_resp_val | mem_resp_nack;
  assign resp_idx = mem_resp_tag[TAG_W-1:0];
  assign dec_htif = resp_any & mem_resp_tag[TAG_W] & pend_htif_q[resp_idx];
  assign dec_core = resp_any & ~mem_resp_tag[TAG_W] & pend_core_q[resp_idx];

  function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] c, input logic inc,
                                               input logic dec);
    if (inc && !dec && c != MaxOut) return c + CntW'(1);
    if (dec && !inc && c != '0) return c - CntW'(1);
    return c;
  endfunction

  always_comb begin
    pend_htif_d = pend_htif_q;
    pend_core_d = pend_core_q;
    if (dec_htif) pend_htif_d[resp_idx] = 1'b0;
    if (dec_core) pend_core_d[resp_idx] = 1'b0;
    if (inc_htif) pend_htif_d[tag_q[TAG_W-1:0]] = 1'b1;
    if (inc_core) pend_core_d[tag_q[TAG_W-1:0]] = 1'b1;
    cnt_htif_d = cnt_next(cnt_htif_q, inc_htif, dec_htif);
    cnt_core_d = cnt_next(cnt_core_q, inc_core, dec_core);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_htif_q  <= '0;
      cnt_core_q  <= '0;
      pend_htif_q <= '0;
      pend_core_q <= '0;
    end else begin
      cnt_htif_q  <= cnt_htif_d;
      cnt_core_q  <= cnt_core_d;
      pend_htif_q <= pend_htif_d;
      pend_core_q <= pend_core_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_hv_q <= 1'b0;
      resp_hn_q <= 1'b0;
      resp_cv_q <= 1'b0;
      resp_cn_q <= 1'b0;
    end else begin
      resp_hv_q <= mem_resp_val & mem_resp_tag[TAG_W];
      resp_hn_q <= mem_resp_nack & mem_resp_tag[TAG_W];
      resp_cv_q <= mem_resp_val & ~mem_resp_tag[TAG_W];
      resp_cn_q <= mem_resp_nack & ~mem_resp_tag[TAG_W];
    end
    resp_data_q <= mem_resp_data;
    resp_tag_q  <= resp_idx;
  end

  assign htif_resp_val  = resp_hv_q;
  assign htif_resp_nack = resp_hn_q;
  assign htif_resp_data = resp_data_q;
  assign htif_resp_tag  = resp_tag_q;
  assign core_resp_val  = resp_cv_q;
  assign core_resp_nack = resp_cn_q;
  assign core_resp_data = resp_data_q;
  assign core_resp_tag  = resp_tag_q;

`ifdef L2ARB_PERF_CNT_EN
  logic [31:0] perf_htif_q, perf_core_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_htif_q  <= '0;
      perf_core_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (htif_req_rdy) perf_htif_q <= perf_htif_q + 32'd1;
      if (core_req_rdy) perf_core_q <= perf_core_q + 32'd1;
      if ((htif_req_val || core_req_val) && !grant) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_htif_grants  = perf_htif_q;
  assign perf_core_grants  = perf_core_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Bench for l2_req_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model (pending-load sets per requester, alternating priority).
module tb_l2_req_arbiter;
  localparam int unsigned ADDR_W = 26;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned TAG_W  = 4;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic reset;
  logic htif_req_val, htif_req_rdy, htif_req_rw;
  logic [13:0] htif_req_addr;
  logic [DATA_W-1:0] htif_req_data, htif_resp_data;
  logic [TAG_W-1:0] htif_req_tag, htif_resp_tag;
  logic htif_resp_val, htif_resp_nack;
  logic core_req_val, core_req_rdy, core_req_rw;
  logic [ADDR_W-1:0] core_req_addr, mem_req_addr;
  logic [DATA_W-1:0] core_req_data, core_resp_data, mem_req_data, mem_resp_data;
  logic [TAG_W-1:0] core_req_tag, core_resp_tag;
  logic core_resp_val, core_resp_nack;
  logic mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_nack;
  logic [1:0] mem_req_rw;
  logic [TAG_W:0] mem_req_tag, mem_resp_tag;
`ifdef L2ARB_PERF_CNT_EN
  logic [31:0] perf_htif_grants, perf_core_grants, perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  l2_req_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .reset(reset),
    .htif_req_val(htif_req_val), .htif_req_rdy(htif_req_rdy), .htif_req_rw(htif_req_rw),
    .htif_req_addr(htif_req_addr), .htif_req_data(htif_req_data), .htif_req_tag(htif_req_tag),
    .htif_resp_val(htif_resp_val), .htif_resp_nack(htif_resp_nack),
    .htif_resp_data(htif_resp_data), .htif_resp_tag(htif_resp_tag),
    .core_req_val(core_req_val), .core_req_rdy(core_req_rdy), .core_req_rw(core_req_rw),
    .core_req_addr(core_req_addr), .core_req_data(core_req_data), .core_req_tag(core_req_tag),
    .core_resp_val(core_resp_val), .core_resp_nack(core_resp_nack),
    .core_resp_data(core_resp_data), .core_resp_tag(core_resp_tag),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_resp_val(mem_resp_val), .mem_resp_nack(mem_resp_nack),
    .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
`ifdef L2ARB_PERF_CNT_EN
    ,
    .perf_htif_grants(perf_htif_grants), .perf_core_grants(perf_core_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: index 1 = HTIF, 0 = core.
  bit m_hold;
  logic [1:0] m_rw;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [TAG_W:0] m_tag;
  bit m_prio_htif;
  bit m_pend[2][16];
  bit e_hv, e_hn, e_cv, e_cn;
  logic [DATA_W-1:0] e_data;
  logic [TAG_W-1:0] e_tag;

  function automatic int outstanding(input int s);
    int n = 0;
    for (int t = 0; t < 16; t++) n += int'(m_pend[s][t]);
    return n;
  endfunction

  // 0 = nobody, 1 = HTIF, 2 = core
  function automatic int winner();
    bit eh, ec;
    if (m_hold) return 0;
    eh = htif_req_val && (htif_req_rw || outstanding(1) < MAX_OUT);
    ec = core_req_val && (core_req_rw || outstanding(0) < MAX_OUT);
    if (eh && (m_prio_htif || !ec)) return 1;
    if (ec) return 2;
    return 0;
  endfunction

  function automatic void model_edge();
    int w, s, t;
    if (reset) begin
      m_hold = 0;
      m_prio_htif = 1;
      for (int i = 0; i < 2; i++) for (int j = 0; j < 16; j++) m_pend[i][j] = 0;
      {e_hv, e_hn, e_cv, e_cn} = 4'b0;
      return;
    end
    w = winner();
    s = int'(mem_resp_tag[TAG_W]);
    t = int'(mem_resp_tag[TAG_W-1:0]);
    e_hv = mem_resp_val && s == 1;
    e_hn = mem_resp_nack && s == 1;
    e_cv = mem_resp_val && s == 0;
    e_cn = mem_resp_nack && s == 0;
    e_data = mem_resp_data;
    e_tag = mem_resp_tag[TAG_W-1:0];
    if (mem_resp_val || mem_resp_nack) m_pend[s][t] = 0;
    if (m_hold) begin
      if (mem_req_rdy) begin
        if (!m_rw[0]) m_pend[int'(m_rw[1])][int'(m_tag[TAG_W-1:0])] = 1;
        m_hold = 0;
      end
    end else if (w == 1) begin
      m_hold = 1; m_rw = {1'b1, htif_req_rw}; m_addr = {12'b0, htif_req_addr};
      m_data = htif_req_data; m_tag = {1'b1, htif_req_tag}; m_prio_htif = 0;
    end else if (w == 2) begin
      m_hold = 1; m_rw = {1'b0, core_req_rw}; m_addr = core_req_addr;
      m_data = core_req_data; m_tag = {1'b0, core_req_tag}; m_prio_htif = 1;
    end
  endfunction

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    htif_req_val = 0; htif_req_rw = 0; htif_req_addr = '0; htif_req_data = '0; htif_req_tag = '0;
    core_req_val = 0; core_req_rw = 0; core_req_addr = '0; core_req_data = '0; core_req_tag = '0;
    mem_req_rdy = 0; mem_resp_val = 0; mem_resp_nack = 0; mem_resp_data = '0; mem_resp_tag = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req_val !== 1'b0) begin
      errors++; $display("FAIL reset_mem_val: got %0b, expected 0", mem_req_val);
    end
    checks++;
    if ({htif_resp_val, htif_resp_nack, core_resp_val, core_resp_nack} !== 4'b0) begin
      errors++; $display("FAIL reset_resp_strobes: got %b, expected 0000",
                         {htif_resp_val, htif_resp_nack, core_resp_val, core_resp_nack});
    end
    advance();
  endtask

  task automatic test_core_load();
    core_req_val = 1; core_req_rw = 0; core_req_addr = 26'h100; core_req_tag = 4'd3;
    core_req_data = 128'hC0DE; mem_req_rdy = 1;
    @(negedge clk);
    checks++;
    if (core_req_rdy !== 1'b1 || htif_req_rdy !== 1'b0) begin
      errors++; $display("FAIL core_load_rdy: got core=%0b htif=%0b, expected 1/0",
                         core_req_rdy, htif_req_rdy);
    end
    advance();
    core_req_tag = 4'd4;
    @(negedge clk);
    checks++;
    if (mem_req_val !== 1'b1 || mem_req_rw !== 2'b00 || mem_req_tag !== 5'h03 ||
        mem_req_addr !== 26'h100) begin
      errors++; $display("FAIL core_load_hold: got val=%0b rw=%b tag=%h addr=%h, expected 1 00 03 100",
                         mem_req_val, mem_req_rw, mem_req_tag, mem_req_addr);
    end
    checks++;
    if (core_req_rdy !== 1'b0) begin
      errors++; $display("FAIL core_load_hold_rdy: got %0b, expected 0", core_req_rdy);
    end
    advance();
    core_req_val = 0; mem_resp_val = 1; mem_resp_tag = 5'h03; mem_resp_data = 128'hBEEF;
    @(negedge clk);
    checks++;
    if (mem_req_val !== 1'b0) begin
      errors++; $display("FAIL core_load_release: got %0b, expected 0", mem_req_val);
    end
    advance();
    mem_resp_val = 0;
    @(negedge clk);
    checks++;
    if (core_resp_val !== 1'b1 || core_resp_tag !== 4'd3 || core_resp_data !== 128'hBEEF ||
        htif_resp_val !== 1'b0) begin
      errors++; $display("FAIL core_load_resp: got cv=%0b tag=%0d data=%h hv=%0b, expected 1 3 beef 0",
                         core_resp_val, core_resp_tag, core_resp_data, htif_resp_val);
    end
    advance();
  endtask

  task automatic test_alternate();
    htif_req_val = 1; htif_req_rw = 1; htif_req_addr = 14'h0AA; htif_req_data = 128'h1111;
    htif_req_tag = 4'd1;
    core_req_val = 1; core_req_rw = 1; core_req_addr = 26'h2BB; core_req_data = 128'h2222;
    core_req_tag = 4'd2; mem_req_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      bit want_h;
      want_h = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (htif_req_rdy !== want_h || core_req_rdy !== !want_h) begin
        errors++; $display("FAIL alternate_grant[%0d]: got htif=%0b core=%0b, expected htif=%0b",
                           i, htif_req_rdy, core_req_rdy, want_h);
      end
      advance();
      @(negedge clk);
      checks++;
      if (mem_req_rw !== (want_h ? 2'b11 : 2'b01) ||
          mem_req_data !== (want_h ? 128'h1111 : 128'h2222)) begin
        errors++; $display("FAIL alternate_req[%0d]: got rw=%b data=%h", i, mem_req_rw, mem_req_data);
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_htif_store();
    htif_req_val = 1; htif_req_rw = 1; htif_req_addr = 14'h3FFF; htif_req_tag = 4'h5;
    htif_req_data = 128'h5A; mem_req_rdy = 0;
    @(negedge clk);
    checks++;
    if (htif_req_rdy !== 1'b1) begin
      errors++; $display("FAIL htif_store_rdy: got %0b, expected 1", htif_req_rdy);
    end
    advance();
    htif_req_val = 0;
    @(negedge clk);
    checks++;
    if (mem_req_addr !== 26'h0003FFF || mem_req_rw !== 2'b11 || mem_req_tag !== 5'h15) begin
      errors++; $display("FAIL htif_store_enc: got addr=%h rw=%b tag=%h, expected 0003fff 11 15",
                         mem_req_addr, mem_req_rw, mem_req_tag);
    end
    advance();
    mem_req_rdy = 1;
    @(negedge clk);
    checks++;
    if (mem_req_val !== 1'b1 || mem_req_tag !== 5'h15) begin
      errors++; $display("FAIL htif_store_stall: got val=%0b tag=%h, expected 1 15",
                         mem_req_val, mem_req_tag);
    end
    advance();
  endtask

  task automatic test_max_out();
    mem_req_rdy = 1;
    for (int t = 0; t < 4; t++) begin
      core_req_val = 1; core_req_rw = 0; core_req_tag = 4'(t); core_req_addr = 26'(t * 16);
      @(negedge clk);
      checks++;
      if (core_req_rdy !== 1'b1) begin
        errors++; $display("FAIL max_out_fill[%0d]: got rdy=%0b, expected 1", t, core_req_rdy);
      end
      advance();
      core_req_val = 0;
      advance();
    end
    core_req_val = 1; core_req_tag = 4'd4;
    htif_req_val = 1; htif_req_rw = 1; htif_req_tag = 4'd9; htif_req_addr = 14'h1;
    @(negedge clk);
    checks++;
    if (core_req_rdy !== 1'b0 || htif_req_rdy !== 1'b1) begin
      errors++; $display("FAIL max_out_block: got core=%0b htif=%0b, expected 0/1",
                         core_req_rdy, htif_req_rdy);
    end
    advance();
    htif_req_val = 0;
    advance();
    @(negedge clk);
    checks++;
    if (core_req_rdy !== 1'b0) begin
      errors++; $display("FAIL max_out_still_blocked: got %0b, expected 0", core_req_rdy);
    end
    mem_resp_val = 1; mem_resp_tag = 5'h00;
    advance();
    mem_resp_val = 0;
    @(negedge clk);
    checks++;
    if (core_req_rdy !== 1'b1) begin
      errors++; $display("FAIL max_out_release: got %0b, expected 1", core_req_rdy);
    end
    advance();
    core_req_val = 0;
    @(negedge clk);
    checks++;
    if (mem_req_tag !== 5'h04 || mem_req_rw !== 2'b00) begin
      errors++; $display("FAIL max_out_grant: got tag=%h rw=%b, expected 04 00", mem_req_tag, mem_req_rw);
    end
    advance();
  endtask

  task automatic test_reset_in_hold();
    htif_req_val = 1; htif_req_rw = 0; htif_req_tag = 4'd7; htif_req_addr = 14'h22; mem_req_rdy = 0;
    @(negedge clk);
    checks++;
    if (htif_req_rdy !== 1'b1) begin
      errors++; $display("FAIL rst_hold_grant: got %0b, expected 1", htif_req_rdy);
    end
    advance();
    htif_req_val = 0;
    advance();
    @(negedge clk);
    checks++;
    if (mem_req_val !== 1'b1 || mem_req_tag !== 5'h17) begin
      errors++; $display("FAIL rst_hold_held: got val=%0b tag=%h, expected 1 17", mem_req_val, mem_req_tag);
    end
    reset = 1;
    advance();
    reset = 0;
    htif_req_val = 1; htif_req_rw = 1; htif_req_tag = 4'd8;
    core_req_val = 1; core_req_rw = 0; core_req_tag = 4'd9;
    @(negedge clk);
    checks++;
    if (mem_req_val !== 1'b0 || htif_req_rdy !== 1'b1 || core_req_rdy !== 1'b0) begin
      errors++; $display("FAIL rst_hold_after: got val=%0b htif=%0b core=%0b, expected 0 1 0",
                         mem_req_val, htif_req_rdy, core_req_rdy);
    end
    advance();
    htif_req_val = 0; mem_req_rdy = 1;
    advance();
    @(negedge clk);
    checks++;
    if (core_req_rdy !== 1'b1) begin
      errors++; $display("FAIL rst_hold_counter: got core rdy=%0b, expected 1", core_req_rdy);
    end
    advance();
    core_req_val = 0; mem_resp_val = 1; mem_resp_tag = 5'h01; mem_resp_data = 128'h77;
    advance();
    mem_resp_val = 0;
    @(negedge clk);
    checks++;
    if (core_resp_val !== 1'b1 || core_resp_tag !== 4'd1) begin
      errors++; $display("FAIL rst_hold_late_resp: got val=%0b tag=%0d, expected 1 1",
                         core_resp_val, core_resp_tag);
    end
    advance();
  endtask

  task automatic test_nack();
    htif_req_val = 1; htif_req_rw = 0; htif_req_tag = 4'd2; htif_req_addr = 14'h40; mem_req_rdy = 1;
    @(negedge clk);
    checks++;
    if (htif_req_rdy !== 1'b1) begin
      errors++; $display("FAIL nack_grant: got %0b, expected 1", htif_req_rdy);
    end
    advance();
    htif_req_val = 0;
    advance();
    mem_resp_nack = 1; mem_resp_tag = 5'h12; mem_resp_data = 128'h99;
    advance();
    mem_resp_nack = 0;
    @(negedge clk);
    checks++;
    if (htif_resp_nack !== 1'b1 || htif_resp_val !== 1'b0 || htif_resp_tag !== 4'd2 ||
        core_resp_val !== 1'b0 || core_resp_nack !== 1'b0) begin
      errors++; $display("FAIL nack_route: got hn=%0b hv=%0b tag=%0d cv=%0b cn=%0b, expected 1 0 2 0 0",
                         htif_resp_nack, htif_resp_val, htif_resp_tag, core_resp_val, core_resp_nack);
    end
    advance();
  endtask

  function automatic logic [TAG_W-1:0] free_tag(input int s);
    int start, t;
    start = int'($urandom_range(15));
    for (int k = 0; k < 16; k++) begin
      t = (start + k) % 16;
      if (!m_pend[s][t] && !(m_hold && int'(m_tag[TAG_W]) == s && !m_rw[0] &&
          int'(m_tag[TAG_W-1:0]) == t)) return 4'(t);
    end
    return 4'(start);
  endfunction

  function automatic logic [TAG_W-1:0] resp_tag_pick(input int s);
    int start, t;
    start = int'($urandom_range(15));
    for (int k = 0; k < 16; k++) begin
      t = (start + k) % 16;
      if (m_pend[s][t]) return 4'(t);
    end
    return 4'(start);
  endfunction

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      int w, s;
      reset = ($urandom_range(99) == 0);
      htif_req_val = 1'($urandom_range(1)); htif_req_rw = ($urandom_range(3) == 0);
      htif_req_addr = 14'($urandom); htif_req_data = {$urandom, $urandom, $urandom, $urandom};
      htif_req_tag = free_tag(1);
      core_req_val = 1'($urandom_range(1)); core_req_rw = ($urandom_range(3) == 0);
      core_req_addr = 26'($urandom); core_req_data = {$urandom, $urandom, $urandom, $urandom};
      core_req_tag = free_tag(0);
      mem_req_rdy = ($urandom_range(2) != 0);
      mem_resp_val = 0; mem_resp_nack = 0;
      mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
      s = int'($urandom_range(1));
      mem_resp_tag = {1'(s), resp_tag_pick(s)};
      if ($urandom_range(2) == 0) begin
        if ($urandom_range(1) == 0) mem_resp_val = 1; else mem_resp_nack = 1;
      end
      @(negedge clk);
      w = winner();
      checks++;
      if (htif_req_rdy !== (w == 1) || core_req_rdy !== (w == 2)) begin
        errors++; $display("FAIL rand_rdy cyc=%0d: got htif=%0b core=%0b, expected winner=%0d",
                           c, htif_req_rdy, core_req_rdy, w);
      end
      checks++;
      if (mem_req_val !== m_hold || (m_hold && ({mem_req_rw, mem_req_addr, mem_req_tag} !==
          {m_rw, m_addr, m_tag} || mem_req_data !== m_data))) begin
        errors++; $display("FAIL rand_req cyc=%0d: got val=%0b rw=%b addr=%h tag=%h, expected %0b %b %h %h",
                           c, mem_req_val, mem_req_rw, mem_req_addr, mem_req_tag,
                           m_hold, m_rw, m_addr, m_tag);
      end
      checks++;
      if ({htif_resp_val, htif_resp_nack, core_resp_val, core_resp_nack} !==
          {e_hv, e_hn, e_cv, e_cn} ||
          ((e_hv || e_hn) && (htif_resp_data !== e_data || htif_resp_tag !== e_tag)) ||
          ((e_cv || e_cn) && (core_resp_data !== e_data || core_resp_tag !== e_tag))) begin
        errors++; $display("FAIL rand_resp cyc=%0d: got strobes=%b, expected %b, tag got %0d/%0d exp %0d",
                           c, {htif_resp_val, htif_resp_nack, core_resp_val, core_resp_nack},
                           {e_hv, e_hn, e_cv, e_cn}, htif_resp_tag, core_resp_tag, e_tag);
      end
      advance();
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_core_load();
    test_alternate();
    test_htif_store();
    test_max_out();
    test_reset_in_hold();
    test_nack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
